tradeoff_vec_driver: RTL

Hardware stimulus/check sequencer that drives the W/found/N interface of the 16-bit tradeoff search core from the requesting side. It pulls W vectors from an upstream valid/ready stream, applies each one to the core and waits for found. It then samples N, compares it against the expected result and keeps pass/error/timeout tallies. It sits beside the core in on-chip self-test builds, replacing the file-driven simulation bench.

---
 rtl/tradeoff_vec_driver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tradeoff_vec_driver.sv
`default_nettype none
// ============================================================================
// Module   : tradeoff_vec_driver
// Purpose  : Feeds W vectors to the tradeoff search core, checks N, keeps tallies.
// Revision : 1.0
// ============================================================================
module tradeoff_vec_driver #(
    parameter int W_BITS      = 30,
    parameter int N_BITS      = 17,
    parameter int EXP_N       = 65535,
    parameter int SETTLE_CYC  = 1,
    parameter int TIMEOUT_CYC = 200000,
    parameter int CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                vec_valid,
    output logic                vec_ready,
    input  logic [W_BITS-1:0]   vec_data,
    input  logic                vec_last,
    output logic                core_clr,
    output logic [W_BITS-1:0]   core_w,
    input  logic                core_found,
    input  logic [N_BITS-1:0]   core_n,
    output logic                busy,
    output logic                done,
    output logic [CNT_BITS-1:0] total_cnt,
    output logic [CNT_BITS-1:0] err_cnt,
    output logic [CNT_BITS-1:0] tmo_cnt,
    output logic [W_BITS-1:0]   fail_w,
    output logic [N_BITS-1:0]   fail_n
);

    localparam int c_TMO_BITS = $clog2(TIMEOUT_CYC + 1);
    localparam int c_SET_BITS = $clog2(SETTLE_CYC + 1);
    localparam logic [c_TMO_BITS-1:0] c_TMO_LAST = c_TMO_BITS'(TIMEOUT_CYC - 1);
    localparam logic [c_SET_BITS-1:0] c_SET_LAST = c_SET_BITS'(SETTLE_CYC - 1);
    localparam logic [N_BITS-1:0]     c_EXP_N    = N_BITS'(EXP_N);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_APPLY  = 3'd2,
        S_ARM    = 3'd3,
        S_WAIT   = 3'd4,
        S_SETTLE = 3'd5,
        S_CHECK  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_TMO_BITS-1:0] r_tmo_cnt;
    logic [c_SET_BITS-1:0] r_set_cnt;
    logic                  r_last;
    logic                  r_tmo;
    logic [N_BITS-1:0]     r_n;

    logic w_start;
    logic w_accept;
    logic w_tmo_hit;
    logic w_settle_end;
    logic w_mismatch;

    assign w_start      = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_accept     = (r_state == S_FETCH) && vec_valid;
    // Found has priority over a simultaneous timeout.
    assign w_tmo_hit    = (r_state == S_WAIT) && !core_found && (r_tmo_cnt == c_TMO_LAST);
    assign w_settle_end = (r_state == S_SETTLE) && (r_set_cnt == c_SET_LAST);
    assign w_mismatch   = (r_n != c_EXP_N);

    function automatic logic [CNT_BITS-1:0] f_sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_BITS'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        vec_ready = 1'b0;
        core_clr  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                vec_ready = 1'b1;
                if (vec_valid) w_next = S_APPLY;
            end
            S_APPLY: begin
                core_clr = 1'b1;
                w_next   = S_ARM;
            end
            // Blanking cycle: a found left over from the previous vector is ignored here.
            S_ARM:    w_next = S_WAIT;
            S_WAIT: begin
                if (core_found)     w_next = S_SETTLE;
                else if (w_tmo_hit) w_next = S_CHECK;
            end
            S_SETTLE: begin
                if (w_settle_end) w_next = S_CHECK;
            end
            S_CHECK:  w_next = r_last ? S_DONE : S_FETCH;
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) w_next = S_FETCH;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_w    <= '0;
            r_last    <= 1'b0;
            r_tmo     <= 1'b0;
            r_tmo_cnt <= '0;
            r_set_cnt <= '0;
            r_n       <= '0;
            total_cnt <= '0;
            err_cnt   <= '0;
            tmo_cnt   <= '0;
            fail_w    <= '0;
            fail_n    <= '0;
        end else begin
            r_tmo_cnt <= (r_state == S_WAIT)   ? r_tmo_cnt + c_TMO_BITS'(1) : '0;
            r_set_cnt <= (r_state == S_SETTLE) ? r_set_cnt + c_SET_BITS'(1) : '0;

            if (w_start) begin
                total_cnt <= '0;
                err_cnt   <= '0;
                tmo_cnt   <= '0;
                fail_w    <= '0;
                fail_n    <= '0;
            end

            if (w_accept) begin
                core_w <= vec_data;
                r_last <= vec_last;
            end

            if (r_state == S_WAIT) begin
                r_tmo <= w_tmo_hit;
            end

            if (w_tmo_hit) begin
                total_cnt <= f_sat_inc(total_cnt);
                err_cnt   <= f_sat_inc(err_cnt);
                tmo_cnt   <= f_sat_inc(tmo_cnt);
                fail_w    <= core_w;
                fail_n    <= '0;
            end

            if (w_settle_end) begin
                r_n <= core_n;
            end

            if ((r_state == S_CHECK) && !r_tmo) begin
                total_cnt <= f_sat_inc(total_cnt);
                if (w_mismatch) begin
                    err_cnt <= f_sat_inc(err_cnt);
                    fail_w  <= core_w;
                    fail_n  <= r_n;
                end
            end
        end
    end

endmodule
`default_nettype wire
